// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit timing.
// Reused by the upstream uart_rx that feeds the FIFO.
package uart_pkg;

  // 100 MHz / 115200 baud
  localparam int DEF_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    CAPT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter draining a synchronous FIFO with a registered read port.
// Pops one byte per frame (rd_en -> data valid next cycle), then shifts it out LSB first.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             tx_n, rd_en_n, busy_n;
  logic             bit_end;

  assign bit_end = (cnt == CNT_MAX);

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tx_n      = tx;
    rd_en_n   = 1'b0;
    case (state)
      IDLE: begin
        tx_n  = 1'b1;
        cnt_n = '0;
        if (!fifo_empty) begin
          rd_en_n = 1'b1;
          state_n = REQ;
        end
      end
      // pop already committed; a late rise of fifo_empty is irrelevant here
      REQ: state_n = CAPT;
      CAPT: begin
        shreg_n = fifo_data;
        tx_n    = 1'b0;
        cnt_n   = '0;
        state_n = START;
      end
      START: begin
        if (bit_end) begin
          cnt_n     = '0;
          tx_n      = shreg[0];
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n     = '0;
          shreg_n   = shreg >> 1;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            tx_n = shreg[1];
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        tx_n    = 1'b1;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and datapath registers; synchronous reset drops any in-flight byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      tx         <= tx_n;
      fifo_rd_en <= rd_en_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with CLKS_PER_BIT=4: FIFO model, tx line decoder
// feeding a byte scoreboard, table-driven cycle-exact frame checks.
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int   chks = 0;
  int   errs = 0;
  int   rd_cnt = 0;
  int   frames = 0;
  int   fcnt = 0;
  logic toggle_en = 1'b0;
  logic toggle_bit = 1'b0;
  logic [7:0] q[$];
  logic [7:0] exp_q[$];

  assign fifo_empty = (fcnt == 0) | toggle_bit;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // {stop, d7..d0, start}, sent from bit 0 upward
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    q.push_back(b);
    exp_q.push_back(b);
    fcnt++;
  endtask

  // Cycle 0 is the current negedge (fifo_empty low before the next edge).
  task automatic check_frame(input logic [9:0] frame);
    logic exp_tx;
    for (int c = 1; c <= 43; c++) begin
      @(negedge clk);
      if (c >= 3 && c <= 42) exp_tx = frame[(c - 3) / CPB];
      else                   exp_tx = 1'b1;
      chk($sformatf("frame_tx_c%0d", c), {31'd0, tx}, {31'd0, exp_tx});
      chk($sformatf("frame_rd_c%0d", c), {31'd0, fifo_rd_en}, {31'd0, (c == 1)});
      chk($sformatf("frame_busy_c%0d", c), {31'd0, busy}, {31'd0, (c >= 1 && c <= 42)});
    end
  endtask

  // FIFO model: data appears the cycle after the rd_en the FIFO samples.
  initial begin
    logic       pend = 1'b0;
    logic       prev_rd = 1'b0;
    logic [7:0] pbyte = 8'h00;
    fifo_data = 8'h00;
    forever begin
      @(negedge clk);
      if (pend) begin
        fifo_data = pbyte;
        pend = 1'b0;
      end else begin
        fifo_data = 8'($urandom);
      end
      if (fifo_rd_en) begin
        rd_cnt++;
        chk("rd_back_to_back", {31'd0, prev_rd}, 32'd0);
        chk("rd_while_tx_low", {31'd0, ~tx}, 32'd0);
        chk("rd_nonempty", (q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (q.size() != 0) begin
          pbyte = q.pop_front();
          fcnt--;
          pend = 1'b1;
        end
      end
      prev_rd = fifo_rd_en;
      toggle_bit = (toggle_en && fcnt > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // tx decoder: samples mid-bit, aborts the frame if reset intervenes.
  initial begin
    logic [7:0] rx;
    logic [7:0] e;
    logic       abort;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        abort = 1'b0;
        rx = 8'h00;
        for (int k = 1; k <= 37; k++) begin
          @(negedge clk);
          if (reset) begin
            abort = 1'b1;
            break;
          end
          if (k == 1) chk("mon_start", {31'd0, tx}, 32'd0);
          else if (k >= 5 && k <= 33 && ((k - 5) % CPB) == 0) rx[(k - 5) / CPB] = tx;
          else if (k == 37) chk("mon_stop", {31'd0, tx}, 32'd1);
        end
        if (!abort) begin
          frames++;
          chks++;
          if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL sb_unexpected: got byte %0h expected none", rx);
          end else begin
            e = exp_q.pop_front();
            chk("sb_byte", {24'd0, rx}, {24'd0, e});
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int rd_base, fr_base;
    bit done;
    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h00, 10'b1_00000000_0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0};
    vecs[3] = '{8'h3C, 10'b1_00111100_0};
    vecs[4] = '{8'h81, 10'b1_10000001_0};

    // reset held 3 cycles with a byte waiting
    reset = 1'b1;
    push_byte(8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_rd", {31'd0, fifo_rd_en}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end
    reset = 1'b0;
    check_frame(vecs[0].frame);

    // table of single frames
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      push_byte(vecs[v].data);
      check_frame(vecs[v].frame);
    end

    // two queued bytes back to back: stop + 3 idle cycles, then next start
    @(negedge clk);
    rd_base = rd_cnt;
    push_byte(8'h00);
    push_byte(8'hFF);
    check_frame(vecs[1].frame);
    check_frame(vecs[2].frame);
    chk("b2b_rd_pulses", rd_cnt - rd_base, 32'd2);

    // FIFO drained: line stays idle, no pops
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("drained_tx", {31'd0, tx}, 32'd1);
      chk("drained_rd", {31'd0, fifo_rd_en}, 32'd0);
    end

    // reset in DATA bit 3 (cycles 19..22), byte dropped
    @(negedge clk);
    push_byte(8'h5A);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rd", {31'd0, fifo_rd_en}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("postrst_rd", {31'd0, fifo_rd_en}, 32'd0);
      chk("postrst_tx", {31'd0, tx}, 32'd1);
    end
    push_byte(8'h3C);
    check_frame(vecs[3].frame);

    // 16 random bytes with fifo_empty toggling
    @(negedge clk);
    rd_base = rd_cnt;
    fr_base = frames;
    toggle_en = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'($urandom));
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fcnt == 0 && !busy) done = 1'b1;
    end
    chk("rand_done", {31'd0, done}, 32'd1);
    toggle_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("rand_rd_pulses", rd_cnt - rd_base, 32'd16);
    chk("rand_frames", frames - fr_base, 32'd16);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", chks, errs);
    $finish;
  end

endmodule
